// File: rtl/win3x3_pkg.sv
// Shared types and constants for the 3x3 window scan controller and its
// weighted-sum datapath.
package win3x3_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SUM_W      = 12;
    localparam int RND        = 8;
    localparam int SHIFT      = 4;
    localparam int PIPE_DEPTH = 3;

    // Row-major 1-2-1 / 2-4-2 / 1-2-1 kernel; weights sum to 16.
    localparam logic [SUM_W-1:0] KW [9] = '{
        12'd1, 12'd2, 12'd1,
        12'd2, 12'd4, 12'd2,
        12'd1, 12'd2, 12'd1
    };

endpackage

// File: rtl/gauss3x3_sum.sv
// Combinational Gaussian-weighted sum of a 3x3 window.
// Index 0 is the top-left pixel; the result never exceeds 4080.
module gauss3x3_sum
    import win3x3_pkg::*;
(
    input  logic [8:0][7:0]   i_pix,
    output logic [SUM_W-1:0]  o_sum
);

    always_comb begin
        o_sum = '0;
        for (int i = 0; i < 9; i++) begin
            o_sum = o_sum + SUM_W'(i_pix[i]) * KW[i];
        end
    end

endmodule

// File: rtl/win3x3_scan_ctrl.sv
// Raster scan of every 3x3 window position, issuing one read per cycle and
// writing one filtered pixel per window after a fixed 4-cycle latency.
module win3x3_scan_ctrl
    import win3x3_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mode,
    output logic        busy,
    output logic        done,
    output logic        rd,
    output logic [7:0]  addr_row_r,
    output logic [7:0]  addr_col_r,
    input  logic [7:0]  sw_pixel_1,
    input  logic [7:0]  sw_pixel_2,
    input  logic [7:0]  sw_pixel_3,
    input  logic [7:0]  sw_pixel_4,
    input  logic [7:0]  sw_pixel_5,
    input  logic [7:0]  sw_pixel_6,
    input  logic [7:0]  sw_pixel_7,
    input  logic [7:0]  sw_pixel_8,
    input  logic [7:0]  sw_pixel_9,
    output logic        wr,
    output logic [7:0]  addr_row_w,
    output logic [7:0]  addr_col_w,
    output logic [7:0]  cl_pixel,
    output state_t      dbg_state
);

    localparam logic [7:0] LAST_COL = 8'(IMG_W - 1);
    localparam logic [7:0] LAST_ROW = 8'(IMG_H - 1);

    state_t                 r_state;
    logic                   r_mode;
    // Bit 0 marks the cycle the memory presents the window; bit PIPE_DEPTH is wr.
    logic [PIPE_DEPTH:0]    r_vld;
    logic [15:0]            r_a0;
    logic [15:0]            r_a1;
    logic [15:0]            r_a2;
    logic [8:0][7:0]        r_pix;
    logic [SUM_W-1:0]       r_sum;
    logic [7:0]             r_p5;
    logic [SUM_W-1:0]       w_sum;

    assign wr        = r_vld[PIPE_DEPTH];
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_mode     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd         <= 1'b0;
            addr_row_r <= '0;
            addr_col_r <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_state    <= SCAN;
                        r_mode     <= mode;
                        busy       <= 1'b1;
                        rd         <= 1'b1;
                        addr_row_r <= '0;
                        addr_col_r <= '0;
                    end
                end
                SCAN: begin
                    if (addr_row_r == LAST_ROW && addr_col_r == LAST_COL) begin
                        rd      <= 1'b0;
                        r_state <= DRAIN;
                    end else if (addr_col_r == LAST_COL) begin
                        addr_col_r <= '0;
                        addr_row_r <= addr_row_r + 8'd1;
                    end else begin
                        addr_col_r <= addr_col_r + 8'd1;
                    end
                end
                DRAIN: begin
                    // Only the final write stage may still be occupied.
                    if (r_vld[PIPE_DEPTH-1:0] == '0) begin
                        r_state <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    gauss3x3_sum u_sum (
        .i_pix (r_pix),
        .o_sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld      <= '0;
            r_a0       <= '0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_pix      <= '0;
            r_sum      <= '0;
            r_p5       <= '0;
            addr_row_w <= '0;
            addr_col_w <= '0;
            cl_pixel   <= '0;
        end else begin
            r_vld <= {r_vld[PIPE_DEPTH-1:0], rd};
            if (rd) begin
                r_a0 <= {addr_row_r, addr_col_r};
            end
            if (r_vld[0]) begin
                r_pix <= {sw_pixel_9, sw_pixel_8, sw_pixel_7,
                          sw_pixel_6, sw_pixel_5, sw_pixel_4,
                          sw_pixel_3, sw_pixel_2, sw_pixel_1};
                r_a1  <= r_a0;
            end
            if (r_vld[1]) begin
                r_sum <= w_sum;
                r_p5  <= r_pix[4];
                r_a2  <= r_a1;
            end
            if (r_vld[2]) begin
                addr_row_w <= r_a2[15:8];
                addr_col_w <= r_a2[7:0];
                cl_pixel   <= r_mode ? r_p5
                                     : 8'((r_sum + SUM_W'(RND)) >> SHIFT);
            end
        end
    end

endmodule
